// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 instruction/data memory arbiter.
package rv32_mem_pkg;

    localparam logic [31:0] MEM_BYTES_DEF = 32'h0025_0000;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    // Data-side context captured at grant for the response cycle.
    typedef struct packed {
        logic       err;
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
    } d_ctx_t;

    // True when a data access must be refused (bad funct3, misaligned, out of range).
    function automatic logic access_err(input logic        we,
                                        input logic [2:0]  f3,
                                        input logic [31:0] addr,
                                        input logic [31:0] mem_bytes);
        logic bad_f3;
        logic misal;
        if (we) begin
            bad_f3 = (f3 > F3_SW);
            misal  = ((f3 == F3_SH) && addr[0]) ||
                     ((f3 == F3_SW) && (addr[1:0] != 2'b00));
        end else begin
            bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            misal  = (((f3 == F3_LH) || (f3 == F3_LHU)) && addr[0]) ||
                     ((f3 == F3_LW) && (addr[1:0] != 2'b00));
        end
        return bad_f3 | misal | (addr >= mem_bytes);
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load word and sign/zero extends it.
module load_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase

        case (funct3)
            F3_LB:   data = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  data = {24'd0, lane_b};
            F3_LH:   data = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  data = {16'd0, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto a single-port memory,
// with data priority bounded by a fetch-starvation streak limit.
module mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 22,
    parameter logic [31:0] MEM_BYTES    = MEM_BYTES_DEF,
    parameter int unsigned D_STREAK_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [ADDR_W-3:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam int unsigned STREAK_W = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;
    owner_e              owner_q, owner_d;
    d_ctx_t              ctx_q, ctx_d;
    logic                fetch_first;
    logic                d_bad;
    logic [31:0]         load_data;
    logic                unused_addr;

    assign unused_addr = ^{i_addr[31:ADDR_W], i_addr[1:0]};
    assign d_bad       = access_err(d_we, d_funct3, d_addr, MEM_BYTES);

    // Grant decision; outputs are forced low while reset is asserted.
    always_comb begin
        fetch_first = i_req && (streak_q == STREAK_W'(D_STREAK_MAX));
        i_gnt       = rst_n && i_req && (fetch_first || !d_req);
        d_gnt       = rst_n && d_req && !i_gnt;
        stall_if    = rst_n && i_req && !i_gnt;
        stall_mem   = rst_n && d_req && !d_gnt;
    end

    always_comb begin
        streak_d = streak_q;
        if (!i_req || i_gnt) begin
            streak_d = '0;
        end else if (d_gnt) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_comb begin
        ctx_d = ctx_q;
        if (d_gnt) begin
            ctx_d.err    = d_bad;
            ctx_d.we     = d_we;
            ctx_d.funct3 = d_funct3;
            ctx_d.off    = d_addr[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
            ctx_q    <= '0;
        end else begin
            streak_q <= streak_d;
            ctx_q    <= ctx_d;
        end
    end

    // Memory port: fetch or legal data access; refused data accesses stay off the bus.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 4'b0000;
        m_addr  = '0;
        m_wdata = 32'd0;
        if (i_gnt) begin
            m_en   = 1'b1;
            m_addr = i_addr[ADDR_W-1:2];
        end else if (d_gnt && !d_bad) begin
            m_en   = 1'b1;
            m_addr = d_addr[ADDR_W-1:2];
            if (d_we) begin
                case (d_funct3)
                    F3_SB: begin
                        m_we    = 4'b0001 << d_addr[1:0];
                        m_wdata = {4{d_wdata[7:0]}};
                    end
                    F3_SH: begin
                        m_we    = 4'b0011 << d_addr[1:0];
                        m_wdata = {2{d_wdata[15:0]}};
                    end
                    default: begin
                        m_we    = 4'b1111;
                        m_wdata = d_wdata;
                    end
                endcase
            end
        end
    end

    // Response-owner FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Response-owner FSM: next state follows this cycle's grant.
    always_comb begin
        owner_d = OWN_NONE;
        if (i_gnt) begin
            owner_d = OWN_INSTR;
        end else if (d_gnt) begin
            owner_d = OWN_DATA;
        end
    end

    load_align u_load_align (
        .funct3 (ctx_q.funct3),
        .off    (ctx_q.off),
        .word   (m_rdata),
        .data   (load_data)
    );

    // Response-owner FSM: outputs.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = 32'd0;
        d_rvalid = 1'b0;
        d_err    = 1'b0;
        d_rdata  = 32'd0;
        case (owner_q)
            OWN_INSTR: begin
                i_rvalid = 1'b1;
                i_rdata  = m_rdata;
            end
            OWN_DATA: begin
                d_rvalid = 1'b1;
                d_err    = ctx_q.err;
                if (!ctx_q.err && !ctx_q.we) begin
                    d_rdata = load_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 22: byte-address width of the shared memory.
REQ-002 Parameter MEM_BYTES, default 32'h00250000: legal byte range [0, MEM_BYTES).
REQ-003 Parameter D_STREAK_MAX, default 2: maximum consecutive data grants while an instruction request waits.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  1  fetch request; i_addr  in  32  fetch byte address.
REQ-007 i_gnt  out  1  fetch accepted this cycle.
REQ-008 i_rvalid  out  1  fetch data valid; i_rdata  out  32  fetch word.
REQ-009 d_req  in  1  data request; d_we  in  1  store when high, load when low.
REQ-010 d_funct3  in  3  RV32I load/store funct3; d_addr  in  32; d_wdata  in  32.
REQ-011 d_gnt  out  1  data accepted; d_rvalid  out  1  data response valid (loads, stores, errors).
REQ-012 d_rdata  out  32  extended load result; d_err  out  1  response is an error.
REQ-013 stall_if, stall_mem  out  1 each  request pending but not granted.
REQ-014 m_en  out  1; m_we  out  4  byte enables; m_addr  out  ADDR_W-2  word address; m_wdata  out  32; m_rdata  in  32, valid one cycle after m_en.

Function
REQ-015 Grant is combinational from registered state; at most one of i_gnt/d_gnt is high per cycle.
REQ-016 Default priority: data over fetch.
REQ-017 Streak counter counts consecutive d_gnt cycles while i_req is high; it clears on any i_gnt or when i_req is low.
REQ-018 When the streak counter equals D_STREAK_MAX and i_req is high, fetch wins over data.
REQ-019 stall_if = i_req & ~i_gnt.
REQ-020 stall_mem = d_req & ~d_gnt.
REQ-021 A granted fetch drives m_en=1, m_we=0, m_addr=i_addr[ADDR_W-1:2].
REQ-022 The fetch response is i_rvalid=1 with i_rdata=m_rdata exactly one cycle after i_gnt.
REQ-023 Data error conditions, each detected at grant:
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]!=0
  - d_addr >= MEM_BYTES
  - load funct3 in {011,110,111}
  - store funct3 > 010
REQ-024 An errored data grant drives m_en=0.
REQ-025 The errored grant returns d_rvalid=1, d_err=1, d_rdata=0 one cycle later.
REQ-026 A granted store drives m_en=1.
REQ-027 Store byte enables: SB m_we=4'b0001<<addr[1:0]; SH m_we=4'b0011<<addr[1:0]; SW m_we=4'b1111.
REQ-028 Store data: m_wdata is d_wdata byte/halfword-replicated across lanes.
REQ-029 A granted store returns d_rvalid=1, d_err=0 one cycle later.
REQ-030 A granted load drives m_en=1, m_we=0.
REQ-031 Load response is one cycle later; funct3 and addr[1:0] are registered at grant.
REQ-032 Load extension: LB/LH sign-extend and LBU/LHU zero-extend the selected lane; LW passes the word.
REQ-033 Response-owner register, states NONE/INSTR/DATA, loads from the grant each cycle.
REQ-034 Back-to-back grants on consecutive cycles are supported; throughput is one access per cycle.
REQ-035 i_rvalid and d_rvalid are single-cycle pulses.
REQ-036 Requests held across a denied cycle are re-arbitrated; requester inputs are sampled only on their grant cycle.

Reset
REQ-037 Reset asserted: owner=NONE, streak counter=0, all outputs 0 (i_rdata, d_rdata=0; d_err=0).
REQ-038 Reset asserted mid-access: the in-flight response is discarded; no rvalid follows release.
REQ-039 The first grant is possible on the first rising edge after rst_n deasserts.

Structure
REQ-040 A shared package rv32_mem_pkg holds:
  - funct3 constants (LB..LHU, SB..SW)
  - owner enumeration
  - MEM_BYTES default
REQ-041 Load-lane selection and sign/zero extension live in sub-module load_align; it is combinational and instantiated once.

Verification
REQ-042 Simultaneous requests: i_req=1 and d_req=1 (LW @0x200000) -> d_gnt=1, stall_if=1; next cycle d_rvalid=1 with the word.
REQ-043 Fetch starvation: d_req held high with i_req for 3 cycles, D_STREAK_MAX=2 -> d_gnt, d_gnt, then i_gnt.
REQ-044 Byte/half access: SB 0xA5 @0x200003 -> m_we=4'b1000; then LB @0x200003 -> d_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
REQ-045 Misaligned access: LW @0x200002 -> m_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-046 Reset mid-access: fetch granted @0x4, rst_n pulsed low before the next edge -> i_rvalid stays 0 and all outputs are 0.
